// File: rtl/jpeg_enc_pkg.sv
// Shared types for the JPEG encoder MCU path.
// mcu_blk_t : one MCU block of one colour component, [row][col][bit], row 0/col 0 at the LSB end.
// mcu_ent_t : one stored FIFO entry, all channels plus the image-last flag (flag in the MSB).
// ptr_width : read/write pointer width for an array of the given depth (one wrap bit).
package jpeg_enc_pkg;

  localparam int unsigned PKG_MCU_SIZE  = 8;
  localparam int unsigned PKG_BIT_WIDTH = 12;
  localparam int unsigned PKG_NUM_CH    = 3;

  typedef logic [PKG_MCU_SIZE-1:0][PKG_MCU_SIZE-1:0][PKG_BIT_WIDTH-1:0] mcu_blk_t;

  typedef struct packed {
    logic                             last;
    mcu_blk_t [PKG_NUM_CH-1:0]        ch;
  } mcu_ent_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mcu_fifo_mem.sv
// Simple-dual-port storage array for mcu_stream_fifo. No reset.
// Ports:
//   clk      : clock, rising edge
//   we_i     : write enable; wdata_i is written to waddr_i
//   waddr_i  : write address
//   wdata_i  : write data
//   re_i     : read enable; mem[raddr_i] is captured into the read register
//   raddr_i  : read address
//   rdata_o  : read register output (holds its value while re_i is low)
module mcu_fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // The read register doubles as the FIFO output register: it holds the
  // head entry even after its array slot has been freed and rewritten.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q        <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mcu_stream_fifo.sv
// Valid/ready FIFO of whole MCU entries (all colour channels + last flag).
// Capacity is DEPTH array entries plus one output register.
// Ports:
//   clk, n_rst           : clock (rising edge), synchronous active-low reset
//   flush                : synchronous clear of all contents (ovf_err kept)
//   s_valid/s_ready      : producer handshake; s_data/s_last stored as one entry
//   m_valid/m_ready      : consumer handshake; m_data/m_last show the head entry
//   count                : entries held (array + output register)
//   almost_full          : registered, count >= AF_LEVEL
//   ovf_err              : sticky, s_valid seen while s_ready low (flush low)
module mcu_stream_fifo
  import jpeg_enc_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MCU_SIZE  = 8,
  parameter int unsigned BIT_WIDTH = 12,
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned AF_LEVEL  = DEPTH - 1
) (
  input  logic                                       clk,
  input  logic                                       n_rst,
  input  logic                                       flush,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [NUM_CH*MCU_SIZE*MCU_SIZE*BIT_WIDTH-1:0] s_data,
  input  logic                                       s_last,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic [NUM_CH*MCU_SIZE*MCU_SIZE*BIT_WIDTH-1:0] m_data,
  output logic                                       m_last,
  output logic [$clog2(DEPTH+1):0]                   count,
  output logic                                       almost_full,
  output logic                                       ovf_err
);

  localparam int unsigned DW = NUM_CH * MCU_SIZE * MCU_SIZE * BIT_WIDTH;
  localparam int unsigned EW = DW + 1;
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam int unsigned CW = $clog2(DEPTH + 1) + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          m_valid_q, m_valid_d;
  logic          s_ready_q, s_ready_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;
  logic [EW-1:0] rdata;

  function automatic logic is_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
  endfunction

  logic arr_full, arr_empty, push, pop, load;

  assign arr_full  = is_full(wr_ptr_q, rd_ptr_q);
  assign arr_empty = (wr_ptr_q == rd_ptr_q);
  assign push      = s_valid & s_ready_q;
  assign pop       = m_valid_q & m_ready;
  assign load      = (~m_valid_q | m_ready) & ~arr_empty;

  mcu_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~flush),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_last, s_data}),
    .re_i    (load & ~flush),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rdata)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    m_valid_d = m_valid_q;
    s_ready_d = s_ready_q;
    af_d      = af_q;
    ovf_d     = ovf_q;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      m_valid_d = 1'b0;
      af_d      = 1'b0;
      s_ready_d = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (load) rd_ptr_d = rd_ptr_q + PW'(1);
      if (load)     m_valid_d = 1'b1;
      else if (pop) m_valid_d = 1'b0;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      af_d = (count_d >= CW'(AF_LEVEL));
      // Drops immediately when the array is about to fill; when leaving full,
      // the current-full term holds it low for one extra cycle so s_ready is
      // a pure register with no path from m_ready.
      s_ready_d = ~(arr_full | is_full(wr_ptr_d, rd_ptr_d));
      ovf_d     = ovf_q | (s_valid & ~s_ready_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
      af_q      <= af_d;
      ovf_q     <= ovf_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = rdata[DW-1:0];
  // The last flag lives in the unreset array; gating with m_valid keeps it 0 after reset.
  assign m_last      = m_valid_q & rdata[DW];
  assign count       = count_q;
  assign almost_full = af_q;
  assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_mcu_stream_fifo.sv
module tb_mcu_stream_fifo;
  import jpeg_enc_pkg::*;

  localparam int unsigned DW = PKG_NUM_CH * PKG_MCU_SIZE * PKG_MCU_SIZE * PKG_BIT_WIDTH;

  logic          clk = 1'b0;
  logic          n_rst, flush, s_valid, s_ready, s_last;
  logic          m_valid, m_ready, m_last, almost_full, ovf_err;
  logic [DW-1:0] s_data, m_data;
  logic [3:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mcu_stream_fifo #(
    .DEPTH     (4),
    .MCU_SIZE  (PKG_MCU_SIZE),
    .BIT_WIDTH (PKG_BIT_WIDTH),
    .NUM_CH    (PKG_NUM_CH),
    .AF_LEVEL  (3)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .count       (count),
    .almost_full (almost_full),
    .ovf_err     (ovf_err)
  );

  // ch0 samples = tag, ch1 = tag*3 + position, ch2 = ~tag
  function automatic mcu_ent_t make_ent(input int tag, input logic last);
    mcu_ent_t e;
    for (int ch = 0; ch < int'(PKG_NUM_CH); ch++)
      for (int r = 0; r < int'(PKG_MCU_SIZE); r++)
        for (int c = 0; c < int'(PKG_MCU_SIZE); c++)
          case (ch)
            0:       e.ch[ch][r][c] = 12'(tag);
            1:       e.ch[ch][r][c] = 12'(tag * 3 + r * 8 + c);
            default: e.ch[ch][r][c] = ~12'(tag);
          endcase
    e.last = last;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int tag, input logic last);
    mcu_ent_t e;
    e = make_ent(tag, last);
    s_data = e.ch;
    s_last = e.last;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    s_data = '0; s_last = 1'b0;
    tick; tick;
    n_cmp++;
    if ({s_ready, m_valid, m_last, almost_full, ovf_err, count} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 0", {s_ready, m_valid, m_last, almost_full, ovf_err, count});
    end
    n_rst = 1'b1;
    tick;
    n_cmp++;
    if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_single;
    mcu_ent_t exp;
    exp = make_ent(1, 1'b0);
    drive(1, 1'b0); s_valid = 1'b1; m_ready = 1'b1;
    tick;
    s_valid = 1'b0;
    n_cmp++;
    if ({m_valid, count} !== {1'b0, 4'd1}) begin
      n_err++; $display("FAIL single_edge1: got valid=%b count=%0d want valid=0 count=1", m_valid, count);
    end
    tick;
    n_cmp++;
    if ({m_valid, count} !== {1'b1, 4'd1}) begin
      n_err++; $display("FAIL single_edge2: got valid=%b count=%0d want valid=1 count=1", m_valid, count);
    end
    n_cmp++;
    if ({m_last, m_data} !== {exp.last, exp.ch}) begin
      n_err++; $display("FAIL single_data: got last=%b d=%h want last=%b d=%h", m_last, m_data[31:0], exp.last, exp.ch[0][0][0]);
    end
    tick;
    m_ready = 1'b0;
    n_cmp++;
    if ({m_valid, count} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL single_pop: got valid=%b count=%0d want valid=0 count=0", m_valid, count);
    end
  endtask

  task automatic test_fill;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(10 + i, (i == 4)); s_valid = 1'b1;
      tick;
      n_cmp++;
      if ({count, s_ready, almost_full} !== {4'(i + 1), (i < 4), (i >= 2)}) begin
        n_err++;
        $display("FAIL fill_%0d: got count=%0d rdy=%b af=%b want count=%0d rdy=%b af=%b",
                 i, count, s_ready, almost_full, i + 1, (i < 4), (i >= 2));
      end
    end
    drive(99, 1'b0);
    #2 s_valid = 1'b0;
    tick;
    n_cmp++;
    if ({ovf_err, count} !== {1'b0, 4'd5}) begin
      n_err++; $display("FAIL ovf_withdrawn: got ovf=%b count=%0d want ovf=0 count=5", ovf_err, count);
    end
    s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    n_cmp++;
    if ({ovf_err, count, s_ready} !== {1'b1, 4'd5, 1'b0}) begin
      n_err++; $display("FAIL ovf_set: got ovf=%b count=%0d rdy=%b want ovf=1 count=5 rdy=0", ovf_err, count, s_ready);
    end
  endtask

  task automatic test_full_pop;
    mcu_ent_t exp;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    exp = make_ent(11, 1'b0);
    n_cmp++;
    if ({count, s_ready, m_valid} !== {4'd4, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL pop_edge: got count=%0d rdy=%b v=%b want count=4 rdy=0 v=1", count, s_ready, m_valid);
    end
    n_cmp++;
    if (m_data !== exp.ch) begin
      n_err++; $display("FAIL pop_head: got %h want %h", m_data[11:0], exp.ch[0][0][0]);
    end
    tick;
    n_cmp++;
    if ({count, s_ready} !== {4'd4, 1'b1}) begin
      n_err++; $display("FAIL ready_rise: got count=%0d rdy=%b want count=4 rdy=1", count, s_ready);
    end
    drive(15, 1'b0); s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    n_cmp++;
    if ({count, s_ready} !== {4'd5, 1'b0}) begin
      n_err++; $display("FAIL refill: got count=%0d rdy=%b want count=5 rdy=0", count, s_ready);
    end
    m_ready = 1'b1;
    for (int t = 11; t <= 15; t++) begin
      exp = make_ent(t, (t == 14));
      n_cmp++;
      if ({m_valid, m_last, m_data} !== {1'b1, exp.last, exp.ch}) begin
        n_err++;
        $display("FAIL drain_%0d: got v=%b last=%b d=%h want v=1 last=%b d=%h",
                 t, m_valid, m_last, m_data[11:0], exp.last, exp.ch[0][0][0]);
      end
      tick;
    end
    m_ready = 1'b0;
    n_cmp++;
    if ({m_valid, count} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL drain_empty: got v=%b count=%0d want v=0 count=0", m_valid, count);
    end
  endtask

  task automatic test_back_to_back;
    int tx = 0, rx = 0, cnt = 0, cyc = 0;
    logic push, pop, hold_v;
    logic [DW-1:0] hold_d;
    mcu_ent_t exp;
    hold_v = 1'b0;
    hold_d = '0;
    while (rx < 20 && cyc < 400) begin
      if (tx < 20) begin drive(100 + tx, (tx % 5 == 4)); s_valid = 1'b1; end
      else s_valid = 1'b0;
      m_ready = 1'($urandom_range(0, 1));
      if (hold_v) begin
        n_cmp++;
        if ({m_valid, m_data} !== {1'b1, hold_d}) begin
          n_err++; $display("FAIL stall_stable: got v=%b d=%h want v=1 d=%h", m_valid, m_data[11:0], hold_d[11:0]);
        end
      end
      push = s_valid & s_ready;
      pop  = m_valid & m_ready;
      if (pop) begin
        exp = make_ent(100 + rx, (rx % 5 == 4));
        n_cmp++;
        if ({m_last, m_data} !== {exp.last, exp.ch}) begin
          n_err++;
          $display("FAIL stream_%0d: got last=%b d=%h want last=%b d=%h",
                   rx, m_last, m_data[11:0], exp.last, exp.ch[0][0][0]);
        end
        rx++;
      end
      hold_v = m_valid & ~m_ready;
      hold_d = m_data;
      tick;
      cyc++;
      if (push) tx++;
      cnt = cnt + int'(push) - int'(pop);
      n_cmp++;
      if (count !== 4'(cnt)) begin
        n_err++; $display("FAIL stream_count: got %0d want %0d", count, cnt);
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    n_cmp++;
    if (rx != 20) begin n_err++; $display("FAIL stream_timeout: got %0d entries want 20", rx); end
  endtask

  task automatic test_flush;
    mcu_ent_t exp;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(30 + i, 1'b0); s_valid = 1'b1;
      tick;
    end
    n_cmp++;
    if (count !== 4'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", count); end
    drive(40, 1'b1); s_valid = 1'b1; m_ready = 1'b1; flush = 1'b1;
    tick;
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    n_cmp++;
    if ({count, m_valid, almost_full, s_ready, ovf_err} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL flush_clear: got count=%0d v=%b af=%b rdy=%b ovf=%b want 0 0 0 1 1",
               count, m_valid, almost_full, s_ready, ovf_err);
    end
    tick; tick;
    n_cmp++;
    if ({count, m_valid} !== {4'd0, 1'b0}) begin
      n_err++; $display("FAIL flush_dropped: got count=%0d v=%b want count=0 v=0", count, m_valid);
    end
    drive(41, 1'b0); s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    tick;
    exp = make_ent(41, 1'b0);
    n_cmp++;
    if ({m_valid, m_data} !== {1'b1, exp.ch}) begin
      n_err++; $display("FAIL flush_next: got v=%b d=%h want v=1 d=%h", m_valid, m_data[11:0], exp.ch[0][0][0]);
    end
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    mcu_ent_t exp;
    m_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(50 + i, 1'b1); s_valid = 1'b1;
      tick;
    end
    s_valid = 1'b0; m_ready = 1'b1; n_rst = 1'b0;
    tick;
    n_cmp++;
    if ({s_ready, m_valid, m_last, almost_full, ovf_err, count} !== 9'b0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %b want 0", {s_ready, m_valid, m_last, almost_full, ovf_err, count});
    end
    n_rst = 1'b1; m_ready = 1'b0;
    tick;
    drive(60, 1'b0); s_valid = 1'b1;
    tick;
    s_valid = 1'b0;
    n_cmp++;
    if ({m_valid, count} !== {1'b0, 4'd1}) begin
      n_err++; $display("FAIL midreset_lat1: got v=%b count=%0d want v=0 count=1", m_valid, count);
    end
    tick;
    exp = make_ent(60, 1'b0);
    n_cmp++;
    if ({m_valid, m_last, m_data, count} !== {1'b1, 1'b0, exp.ch, 4'd1}) begin
      n_err++;
      $display("FAIL midreset_push: got v=%b last=%b d=%h count=%0d want v=1 last=0 d=%h count=1",
               m_valid, m_last, m_data[11:0], count, exp.ch[0][0][0]);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_full_pop;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
